alu_seq: RTL

Parametrised, handshaked successor to the core's combinational ALU. It performs single-cycle ALU operations and iterative multi-cycle multiply, plus divide when configured in. Results and a zero flag are registered and returned over a valid/ready interface. It sits in the core's execute stage, so the pipeline can stall on long operations without any external sequencing.

---
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops plus iterative shift-add multiply.
// Define ALU_SEQ_DIV_EN to compile in the restoring divider (divu/remu).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_SGTU  = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] acc_reg;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_reg;      // multiplier-then-product-low / dividend-then-quotient
    logic [WIDTH-1:0] b_reg;       // multiplicand / divisor
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             out_valid_reg;

    logic             accept;
    logic             iter_op;
    logic             div_op;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;

`ifdef ALU_SEQ_DIV_EN
    assign div_op  = (opcode == OP_DIVU) || (opcode == OP_REMU);
`else
    assign div_op  = 1'b0;
`endif
    assign iter_op = (opcode == OP_MUL) || (opcode == OP_MULHU) || div_op;

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] n1_rev;
    logic [WIDTH-1:0] rs_in;
    logic [WIDTH-1:0] rs_out;
    logic [WIDTH-1:0] sll_res;
    logic             rs_fill;
    logic [WIDTH-1:0] alu_res;

    assign shamt = num2[SHW-1:0];

    // Left shifts reuse the right barrel shifter on bit-reversed data.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_rev
            assign n1_rev[gi]  = num1[WIDTH-1-gi];
            assign sll_res[gi] = rs_out[WIDTH-1-gi];
        end
    endgenerate

    assign rs_in   = (opcode == OP_SLL) ? n1_rev : num1;
    assign rs_fill = (opcode == OP_SRA) && num1[WIDTH-1];

    always_comb begin
        rs_out = rs_in;
        for (int i = 0; i < SHW; i++) begin
            if (shamt[i]) begin
                rs_out = (rs_out >> (1 << i)) |
                         (rs_fill ? ~({WIDTH{1'b1}} >> (1 << i)) : {WIDTH{1'b0}});
            end
        end
    end

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = num1 + num2;
            OP_SUB:  alu_res = num1 - num2;
            OP_AND:  alu_res = num1 & num2;
            OP_OR:   alu_res = num1 | num2;
            OP_XOR:  alu_res = num1 ^ num2;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (num1 < num2)};
            OP_SGTU: alu_res = {{(WIDTH-1){1'b0}}, (num1 > num2)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
            OP_SLL:  alu_res = sll_res;
            OP_SRL:  alu_res = rs_out;
            OP_SRA:  alu_res = rs_out;
            default: alu_res = '0;
        endcase
    end

    // ---------------- iterative datapath ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] iter_res;

    assign mul_sum = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;

    assign div_shift = {acc_reg, lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    // A set top bit means the shifted remainder already exceeds any divisor.
    assign div_ok    = div_shift[WIDTH] || !div_diff[WIDTH];

    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        if ((op_reg == OP_DIVU) || (op_reg == OP_REMU)) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {lo_reg[WIDTH-2:0], div_ok};
        end
    end
`else
    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
`endif

    assign iter_res = ((op_reg == OP_MUL) || (op_reg == OP_DIVU)) ? step_lo : step_hi;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_reg        <= '0;
            acc_reg       <= '0;
            lo_reg        <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        op_reg <= opcode;
                        if (iter_op) begin
                            state_reg     <= BUSY;
                            cnt_reg       <= '0;
                            acc_reg       <= '0;
                            lo_reg        <= div_op ? num1 : num2;
                            b_reg         <= div_op ? num2 : num1;
                            out_valid_reg <= 1'b0;
                        end else begin
                            state_reg     <= DONE;
                            result_reg    <= alu_res;
                            zero_reg      <= (alu_res == '0);
                            out_valid_reg <= 1'b1;
                        end
                    end else if ((state_reg == DONE) && out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                BUSY: begin
                    acc_reg <= step_hi;
                    lo_reg  <= step_lo;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == SHW'(WIDTH - 1)) begin
                        state_reg     <= DONE;
                        result_reg    <= iter_res;
                        zero_reg      <= (iter_res == '0);
                        out_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
